// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane geometry.
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam int LANE_W  = 8;
   localparam int N_LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, alignment check,
// and load-data extraction with zero/sign extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]              size,
   input  logic                    sext,
   input  logic [1:0]              addr_lo,
   input  logic [31:0]             wdata,
   input  logic [31:0]             rdata,
   output logic [N_LANES-1:0]      wren,
   output logic [31:0]             wdata_rep,
   output logic                    err,
   output logic [31:0]             rdata_ext
);

   logic [LANE_W-1:0] byte_sel;
   logic [15:0]       half_sel;

   always_comb begin
      byte_sel  = rdata[{addr_lo, 3'b000} +: LANE_W];
      half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      wren      = '0;
      wdata_rep = wdata;
      err       = 1'b0;
      rdata_ext = '0;
      case (size)
         SIZE_BYTE: begin
            wren      = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sext & byte_sel[7]}}, byte_sel};
         end
         SIZE_HALF: begin
            err       = addr_lo[0];
            wren      = 4'b0011 << addr_lo;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{sext & half_sel[15]}}, half_sel};
         end
         SIZE_WORD: begin
            err       = (addr_lo != 2'b00);
            wren      = 4'b1111;
            rdata_ext = rdata;
         end
         default: err = 1'b1;
      endcase
      // A flagged access must never touch memory or return data.
      if (err) begin
         wren      = '0;
         rdata_ext = '0;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit top: request latch, IDLE/ACCESS/RESP sequencing and response register.
//
// state     | meaning
// ST_IDLE   | req_ready high, waiting for req_valid
// ST_ACCESS | single memory cycle: store lanes enabled or load word captured
// ST_RESP   | resp_valid high, held until resp_ready
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wren,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        resp_valid_q, resp_valid_d;
   logic        req_ready_q, req_ready_d;

   logic [3:0]  al_wren;
   logic [31:0] al_wdata;
   logic        al_err;
   logic [31:0] al_rdata;

   lsu_lane_align u_align (
      .size      (size_q),
      .sext      (sext_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (mem_rdata),
      .wren      (al_wren),
      .wdata_rep (al_wdata),
      .err       (al_err),
      .rdata_ext (al_rdata)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      sext_d       = sext_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               sext_d  = req_sext;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            resp_err_d   = al_err;
            resp_rdata_d = (we_q || al_err) ? 32'h0 : al_rdata;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         size_q       <= SIZE_BYTE;
         sext_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         sext_q       <= sext_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         resp_valid_q <= resp_valid_d;
         req_ready_q  <= req_ready_d;
      end
   end

   // Write enables are gated by rst directly so a reset in ACCESS drops the store.
   assign mem_wren   = (state_q == ST_ACCESS && we_q && !rst) ? al_wren : 4'b0000;
   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = al_wdata;
   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
